mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single-port registered-read RAM.
// Grants are combinational; a one-entry tracker routes the next-cycle read data to its owner.
module mem_arbiter #(
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_d,
    input  logic [3:0]  m1_we,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_d,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_q
);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    // The pointer holds the last granted master, so reset loads the opposite of RESET_PRIO.
    localparam master_t RESET_LAST = (RESET_PRIO == 0) ? M1 : M0;

    master_t last_q;
    master_t resp_owner_q;
    logic    resp_valid_q;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                if (last_q == M1) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    always_comb begin
        mem_en   = m0_gnt | m1_gnt;
        mem_addr = '0;
        mem_d    = '0;
        mem_we   = '0;
        if (m0_gnt) begin
            mem_addr = m0_addr;
        end else if (m1_gnt) begin
            mem_addr = m1_addr;
            mem_d    = m1_d;
            mem_we   = m1_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q       <= RESET_LAST;
            resp_valid_q <= 1'b0;
            resp_owner_q <= M0;
        end else begin
            resp_valid_q <= m0_gnt | m1_gnt;
            if (m0_gnt) begin
                last_q       <= M0;
                resp_owner_q <= M0;
            end else if (m1_gnt) begin
                last_q       <= M1;
                resp_owner_q <= M1;
            end
        end
    end

    // Responses are also masked while rst_n is low, so an access in flight when reset asserts never surfaces.
    always_comb begin
        m0_rvalid = rst_n & resp_valid_q & (resp_owner_q == M0);
        m1_rvalid = rst_n & resp_valid_q & (resp_owner_q == M1);
        m0_rdata  = m0_rvalid ? mem_q : '0;
        m1_rdata  = m1_rvalid ? mem_q : '0;
    end

endmodule
